mem_stream_reader: RTL and testbench

//  Read-side master for the single-clock, async-read vector/matrix memory.
//  - Accepts a (start address, word count) command.
//  - Drives the memory read address and captures each word into an output register.
//  - Streams the words to the MVM datapath over a valid/ready interface with full backpressure.
//  - Sustains one word per cycle while the consumer holds ready high.

---
 rtl/mem_stream_reader.sv | 132 +++++++++++++
 tb/tb_mem_stream_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: reads a (start address, word count) command from an async-read
// memory and streams the words out; first beat one cycle after the command is taken, then one beat/cycle.
// Full valid/ready backpressure: a stalled beat holds data/last stable until the consumer takes it.
// Ports:
//   i_clk, i_rst                         clock; synchronous active-high reset
//   i_start, i_start_addr, i_num_words   command, sampled only while idle
//   o_busy, o_done                       command in progress / one-cycle completion pulse
//   o_mem_raddr, i_mem_rdata             async-read memory port
//   o_ostream_data/valid/last, i_ostream_ready   registered output stream
module mem_stream_reader #(
  parameter int DATAW = 64,
  parameter int DEPTH = 256,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int LENW  = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [ADDRW-1:0] i_start_addr,
  input  logic [LENW-1:0]  i_num_words,
  output logic             o_busy,
  output logic             o_done,
  output logic [ADDRW-1:0] o_mem_raddr,
  input  logic [DATAW-1:0] i_mem_rdata,
  output logic [DATAW-1:0] o_ostream_data,
  output logic             o_ostream_valid,
  output logic             o_ostream_last,
  input  logic             i_ostream_ready
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t           r_state;
  logic [ADDRW-1:0] r_rd_ptr;
  logic [LENW-1:0]  r_remaining;
  logic [DATAW-1:0] r_data;
  logic             r_valid;
  logic             r_last;
  logic             r_done;

  state_t           w_state_nxt;
  logic [ADDRW-1:0] w_rd_ptr_nxt;
  logic [LENW-1:0]  w_remaining_nxt;
  logic [DATAW-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic             w_last_nxt;
  logic             w_done_nxt;
  logic             w_load;
  logic             w_hs;

  // A new word may enter the output register when it is empty or being drained
  // this cycle; that overlap is what gives one beat per cycle.
  assign w_load = (r_state == S_STREAM) && (r_remaining != '0) && (!r_valid || i_ostream_ready);
  assign w_hs   = r_valid && i_ostream_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_remaining_nxt = r_remaining;
    w_data_nxt      = r_data;
    w_valid_nxt     = r_valid;
    w_last_nxt      = r_last;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_num_words != '0) begin
            w_rd_ptr_nxt    = i_start_addr;
            w_remaining_nxt = i_num_words;
            w_state_nxt     = S_STREAM;
          end else begin
            // Zero-length command completes immediately without any beat.
            w_done_nxt = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (w_hs && !w_load) begin
          w_valid_nxt = 1'b0;
        end
        if (w_load) begin
          w_data_nxt      = i_mem_rdata;
          w_valid_nxt     = 1'b1;
          w_last_nxt      = (r_remaining == LENW'(1));
          // Explicit wrap so non-power-of-two depths stay in range.
          w_rd_ptr_nxt    = (r_rd_ptr == ADDRW'(DEPTH - 1)) ? '0 : r_rd_ptr + ADDRW'(1);
          w_remaining_nxt = r_remaining - LENW'(1);
        end
        // Last beat taken: remaining is already zero, so no load can coincide.
        if (w_hs && r_last) begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_remaining <= w_remaining_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_last      <= w_last_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = r_done;
  assign o_mem_raddr     = r_rd_ptr;
  assign o_ostream_data  = r_data;
  assign o_ostream_valid = r_valid;
  assign o_ostream_last  = r_last;

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;
  localparam int DATAW = 64;
  localparam int DEPTH = 256;
  localparam int ADDRW = 8;
  localparam int LENW  = 9;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [ADDRW-1:0] i_start_addr;
  logic [LENW-1:0]  i_num_words;
  logic             o_busy;
  logic             o_done;
  logic [ADDRW-1:0] o_mem_raddr;
  logic [DATAW-1:0] i_mem_rdata;
  logic [DATAW-1:0] o_ostream_data;
  logic             o_ostream_valid;
  logic             o_ostream_last;
  logic             i_ostream_ready;

  logic [DATAW-1:0] mem [DEPTH];
  assign i_mem_rdata = mem[o_mem_raddr];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  mem_stream_reader #(.DATAW(DATAW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_start_addr(i_start_addr),
    .i_num_words(i_num_words), .o_busy(o_busy), .o_done(o_done),
    .o_mem_raddr(o_mem_raddr), .i_mem_rdata(i_mem_rdata),
    .o_ostream_data(o_ostream_data), .o_ostream_valid(o_ostream_valid),
    .o_ostream_last(o_ostream_last), .i_ostream_ready(i_ostream_ready)
  );

  typedef struct {
    logic [ADDRW-1:0] addr;
    logic [LENW-1:0]  len;
    logic [15:0]      pat;        // ready per cycle after the start edge, repeating
    int               inject;     // cycle at which a spurious start is pulsed, -1 none
    int               exp_beats;
    logic [DATAW-1:0] exp_first;
    logic [DATAW-1:0] exp_last;
    int               exp_cycles; // cycles from start edge to done visible
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Issues one command and follows it to completion, checking every beat against
  // the memory contents at addresses addr, addr+1, ... modulo DEPTH.
  task automatic run_cmd(input logic [ADDRW-1:0] addr, input logic [LENW-1:0] len,
                         input logic [15:0] pat, input bit rnd, input int inject,
                         input string tag, output int beats,
                         output logic [DATAW-1:0] first_d, output logic [DATAW-1:0] last_d,
                         output int cycles);
    logic [DATAW-1:0] exp_q[$];
    logic [DATAW-1:0] e;
    logic [DATAW-1:0] prev_d;
    logic             prev_l;
    bit               prev_stall;
    bit               exp_done;
    bit               finished;
    int               cyc;
    exp_q.delete();
    for (int k = 0; k < int'(len); k++) exp_q.push_back(mem[(int'(addr) + k) % DEPTH]);
    beats = 0; first_d = '0; last_d = '0;
    prev_d = '0; prev_l = 1'b0; prev_stall = 0;
    exp_done = (len == 0); finished = 0; cyc = 0;
    i_start = 1'b1; i_start_addr = addr; i_num_words = len;
    step();
    i_start = 1'b0;
    while (!finished && cyc < 2000) begin
      chk({tag, ".done"}, o_done, exp_done);
      if (exp_done) begin
        finished = 1;
        chk({tag, ".valid_at_done"}, o_ostream_valid, 0);
        chk({tag, ".busy_at_done"}, o_busy, 0);
      end else begin
        chk({tag, ".busy"}, o_busy, 1);
        if (prev_stall) begin
          chk({tag, ".hold_valid"}, o_ostream_valid, 1);
          chk({tag, ".hold_data"}, o_ostream_data, prev_d);
          chk({tag, ".hold_last"}, o_ostream_last, prev_l);
        end
        i_start = (cyc == inject);
        if (cyc == inject) begin
          i_start_addr = '0; i_num_words = LENW'(8);
        end
        i_ostream_ready = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 16];
        exp_done = 0;
        if (o_ostream_valid && i_ostream_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.extra_beat: got data %0d, expected no beat", tag, o_ostream_data);
          end else begin
            e = exp_q.pop_front();
            chk({tag, ".data"}, o_ostream_data, e);
            chk({tag, ".last"}, o_ostream_last, (exp_q.size() == 0));
            if (beats == 0) first_d = e;
            last_d = e;
            beats++;
            exp_done = (exp_q.size() == 0);
          end
        end
        prev_stall = o_ostream_valid && !i_ostream_ready;
        prev_d = o_ostream_data;
        prev_l = o_ostream_last;
        step();
        cyc++;
      end
    end
    i_start = 1'b0;
    if (!finished) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: got no done after %0d cycles, expected done", tag, cyc);
    end
    chk({tag, ".beat_count"}, beats, len);
    cycles = cyc;
  endtask

  initial begin
    int               beats, cycles;
    logic [DATAW-1:0] fd, ld;
    logic [ADDRW-1:0] ra;
    logic [LENW-1:0]  rl;

    //            addr    len     pat       inj exp_beats first last cycles
    tbl[0] = '{8'd5,   9'd4,   16'hFFFF, -1, 4,   64'd105, 64'd108, 5};
    tbl[1] = '{8'd5,   9'd4,   16'hFFE9, -1, 4,   64'd105, 64'd108, 8};
    tbl[2] = '{8'd254, 9'd4,   16'hFFFF, -1, 4,   64'd354, 64'd101, 5};
    tbl[3] = '{8'd0,   9'd0,   16'hFFFF, -1, 0,   64'd0,   64'd0,   0};
    tbl[4] = '{8'd5,   9'd4,   16'hFFFF, 2,  4,   64'd105, 64'd108, 5};
    tbl[5] = '{8'd255, 9'd1,   16'hFFFF, -1, 1,   64'd355, 64'd355, 2};
    tbl[6] = '{8'd10,  9'd2,   16'h5555, -1, 2,   64'd110, 64'd111, 5};
    tbl[7] = '{8'd0,   9'd256, 16'hFFFF, -1, 256, 64'd100, 64'd355, 257};

    for (int i = 0; i < DEPTH; i++) mem[i] = DATAW'(i + 100);

    // Reset held two cycles with start asserted.
    i_rst = 1'b1; i_start = 1'b1; i_start_addr = 8'd5; i_num_words = 9'd4;
    i_ostream_ready = 1'b0;
    step(); step();
    chk("rst.busy", o_busy, 0);
    chk("rst.done", o_done, 0);
    chk("rst.valid", o_ostream_valid, 0);
    chk("rst.last", o_ostream_last, 0);
    chk("rst.data", o_ostream_data, 0);
    chk("rst.raddr", o_mem_raddr, 0);
    i_rst = 1'b0; i_start = 1'b0;
    repeat (3) step();
    chk("post_rst.busy", o_busy, 0);
    chk("post_rst.valid", o_ostream_valid, 0);

    // Commands run back to back: each new start lands in the previous done cycle.
    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].addr, tbl[i].len, tbl[i].pat, 1'b0, tbl[i].inject,
              $sformatf("vec%0d", i), beats, fd, ld, cycles);
      chk($sformatf("vec%0d.beats", i), beats, tbl[i].exp_beats);
      chk($sformatf("vec%0d.cycles", i), cycles, tbl[i].exp_cycles);
      if (tbl[i].exp_beats > 0) begin
        chk($sformatf("vec%0d.first", i), fd, tbl[i].exp_first);
        chk($sformatf("vec%0d.last_word", i), ld, tbl[i].exp_last);
      end
    end

    // Reset mid-stream after two beats of a six-word command.
    i_ostream_ready = 1'b1;
    i_start = 1'b1; i_start_addr = 8'd0; i_num_words = 9'd6;
    step();
    i_start = 1'b0;
    step(); step(); step();
    chk("mid_rst.pre_valid", o_ostream_valid, 1);
    chk("mid_rst.pre_data", o_ostream_data, 102);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("mid_rst.valid", o_ostream_valid, 0);
    chk("mid_rst.busy", o_busy, 0);
    chk("mid_rst.last", o_ostream_last, 0);
    chk("mid_rst.done", o_done, 0);
    run_cmd(8'd10, 9'd2, 16'hFFFF, 1'b0, -1, "after_rst", beats, fd, ld, cycles);
    chk("after_rst.first", fd, 110);
    chk("after_rst.last_word", ld, 111);
    chk("after_rst.cycles", cycles, 3);

    // Randomized commands and ready patterns over random memory contents.
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    for (int t = 0; t < 30; t++) begin
      ra = ADDRW'($urandom_range(0, DEPTH - 1));
      rl = ($urandom_range(0, 9) == 0) ? LENW'($urandom_range(0, DEPTH))
                                       : LENW'($urandom_range(0, 12));
      run_cmd(ra, rl, 16'h0, 1'b1, ($urandom_range(0, 3) == 0) ? 1 : -1,
              $sformatf("rnd%0d", t), beats, fd, ld, cycles);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
